// File: rtl/profir_synth.sv
// profir_synth: 8-band 128-tap FIR synthesis bank summing the band outputs into one sample
module profir_synth #(
  parameter int OUT_SHIFT = 16,
  parameter int ACC_W = 48
) (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [15:0] datain0,
  input  logic signed [15:0] datain1,
  input  logic signed [15:0] datain2,
  input  logic signed [15:0] datain3,
  input  logic signed [15:0] datain4,
  input  logic signed [15:0] datain5,
  input  logic signed [15:0] datain6,
  input  logic signed [15:0] datain7,
  input  logic               din_enable,
  output logic               busy,
  output logic [5:0]         coeffaddress,
  input  logic [35:0]        coeff0,
  input  logic [35:0]        coeff1,
  input  logic [35:0]        coeff2,
  input  logic [35:0]        coeff3,
  input  logic [35:0]        coeff4,
  input  logic [35:0]        coeff5,
  input  logic [35:0]        coeff6,
  input  logic [35:0]        coeff7,
  output logic signed [15:0] dataout,
  output logic               dout_valid
);
  typedef enum logic [2:0] {IDLE, SHIFT, ADDR, DRAIN, OUT} state_t;
  localparam logic signed [ACC_W-1:0] MAX_V = 32767;
  localparam logic signed [ACC_W-1:0] MIN_V = -32768;
  state_t state_q;
  logic [6:0] cnt_q;
  logic busy_q, dv_q, v1_q, pv_q, accept;
  logic [5:0] addr_q, addr1_q;
  logic signed [15:0] din [8];
  logic [35:0] cf [8];
  logic signed [15:0] x_q [8][128];
  logic signed [33:0] pe_q [8], po_q [8], pe_d [8], po_d [8];
  logic signed [ACC_W-1:0] acc_q, psum_d, sh_d;
  logic signed [15:0] dout_q, sat_d;
  assign din = '{datain0, datain1, datain2, datain3, datain4, datain5, datain6, datain7};
  assign cf = '{coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7};
  assign accept = din_enable && state_q == IDLE;
  assign busy = busy_q;
  assign coeffaddress = addr_q;
  assign dataout = dout_q;
  assign dout_valid = dv_q;
  // Frame sequencing: cnt_q counts edges since the accepting edge; address sweep runs off it
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      busy_q <= 1'b0;
      dv_q <= 1'b0;
      dout_q <= '0;
      addr_q <= '0;
    end else begin
      dv_q <= 1'b0;
      cnt_q <= busy_q ? cnt_q + 7'd1 : '0;
      addr_q <= (busy_q && cnt_q < 7'd64) ? cnt_q[5:0] : '0;
      case (state_q)
        IDLE: if (din_enable) begin
          state_q <= SHIFT;
          busy_q <= 1'b1;
        end
        SHIFT: state_q <= ADDR;
        ADDR: if (cnt_q == 7'd64) state_q <= DRAIN;
        DRAIN: if (cnt_q == 7'd66) state_q <= OUT;
        OUT: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          dv_q <= 1'b1;
          dout_q <= sat_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Per-band delay lines shift once per accepted frame and survive until reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 8; k++)
        for (int n = 0; n < 128; n++) x_q[k][n] <= '0;
    end else if (accept) begin
      for (int k = 0; k < 8; k++) begin
        for (int n = 1; n < 128; n++) x_q[k][n] <= x_q[k][n-1];
        x_q[k][0] <= din[k];
      end
    end
  end
  // Even/odd tap products against the word returned for the previous cycle's address
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      pe_d[k] = 34'(x_q[k][{addr1_q, 1'b0}]) * 34'($signed(cf[k][17:0]));
      po_d[k] = 34'(x_q[k][{addr1_q, 1'b1}]) * 34'($signed(cf[k][35:18]));
    end
  end
  // Full-precision sum of the 16 registered products
  always_comb begin
    psum_d = '0;
    for (int k = 0; k < 8; k++) psum_d = psum_d + ACC_W'(pe_q[k]) + ACC_W'(po_q[k]);
  end
  // Arithmetic scale-down then clamp to the 16-bit output range
  always_comb begin
    sh_d = acc_q >>> OUT_SHIFT;
    sat_d = sh_d > MAX_V ? 16'sh7fff : sh_d < MIN_V ? 16'sh8000 : sh_d[15:0];
  end
  // Multiply/accumulate pipeline: address -> coeff word -> products -> accumulator
  always_ff @(posedge clock) begin
    if (reset) begin
      addr1_q <= '0;
      v1_q <= 1'b0;
      pv_q <= 1'b0;
      acc_q <= '0;
      for (int k = 0; k < 8; k++) begin
        pe_q[k] <= '0;
        po_q[k] <= '0;
      end
    end else begin
      addr1_q <= addr_q;
      v1_q <= state_q == ADDR;
      pv_q <= v1_q;
      for (int k = 0; k < 8; k++) begin
        pe_q[k] <= pe_d[k];
        po_q[k] <= po_d[k];
      end
      acc_q <= accept ? '0 : pv_q ? acc_q + psum_d : acc_q;
    end
  end
endmodule

// File: tb/tb_profir_synth.sv
// tb_profir_synth: directed and reference-model checks of the 8-band synthesis bank
module tb_profir_synth;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic din_enable = 1'b0;
  logic signed [15:0] din [8];
  logic [35:0] rom [8][64];
  logic [35:0] cq [8];
  logic busy, dout_valid;
  logic [5:0] coeffaddress;
  logic signed [15:0] dataout;
  int checks = 0;
  int errors = 0;
  int h [8][128];
  int mx [8][128];

  profir_synth dut (
    .clock(clock), .reset(reset),
    .datain0(din[0]), .datain1(din[1]), .datain2(din[2]), .datain3(din[3]),
    .datain4(din[4]), .datain5(din[5]), .datain6(din[6]), .datain7(din[7]),
    .din_enable(din_enable), .busy(busy), .coeffaddress(coeffaddress),
    .coeff0(cq[0]), .coeff1(cq[1]), .coeff2(cq[2]), .coeff3(cq[3]),
    .coeff4(cq[4]), .coeff5(cq[5]), .coeff6(cq[6]), .coeff7(cq[7]),
    .dataout(dataout), .dout_valid(dout_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    for (int k = 0; k < 8; k++) cq[k] <= rom[k][coeffaddress];

  task automatic clear_rom;
    for (int k = 0; k < 8; k++)
      for (int a = 0; a < 64; a++) rom[k][a] = '0;
  endtask

  task automatic set_tap(input int k, input int n, input int v);
    logic [17:0] t;
    t = 18'(v);
    if (n % 2 == 1) rom[k][n/2][35:18] = t;
    else rom[k][n/2][17:0] = t;
  endtask

  task automatic clear_din;
    for (int k = 0; k < 8; k++) din[k] = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Called at a negedge while idle; returns at the negedge where dout_valid is seen
  task automatic send_frame(output logic signed [15:0] y, output int lat);
    din_enable = 1'b1;
    @(negedge clock);
    din_enable = 1'b0;
    clear_din();
    lat = 0;
    while (dout_valid !== 1'b1 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    y = dataout;
  endtask

  task automatic test_reset;
    int nv, lat;
    logic signed [15:0] y;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++; if (dataout !== 16'sd0) begin errors++; $display("FAIL reset_dataout got %0d exp 0", dataout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b exp 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (coeffaddress !== 6'd0) begin errors++; $display("FAIL reset_coeffaddress got %0d exp 0", coeffaddress); end
    clear_rom();
    for (int k = 0; k < 8; k++) begin
      set_tap(k, 0, 65536);
      set_tap(k, 1, 65536);
    end
    din[0] = 16'sd1234;
    din_enable = 1'b1;
    @(negedge clock);
    din_enable = 1'b0;
    clear_din();
    repeat (20) @(negedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b exp 1", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checks++; if (dataout !== 16'sd0) begin errors++; $display("FAIL abort_dataout got %0d exp 0", dataout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL abort_dout_valid got %b exp 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (coeffaddress !== 6'd0) begin errors++; $display("FAIL abort_coeffaddress got %0d exp 0", coeffaddress); end
    nv = 0;
    repeat (80) begin
      @(negedge clock);
      if (dout_valid === 1'b1) nv++;
    end
    checks++; if (nv !== 0) begin errors++; $display("FAIL abort_no_valid got %0d pulses exp 0", nv); end
    send_frame(y, lat);
    checks++; if (y !== 16'sd0) begin errors++; $display("FAIL history_lost got %0d exp 0", y); end
    checks++; if (lat !== 68) begin errors++; $display("FAIL history_lost_latency got %0d exp 68", lat); end
  endtask

  task automatic test_impulse;
    int lat, e;
    logic signed [15:0] y;
    do_reset();
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 128; n++) set_tap(k, n, 65536);
    din[0] = 16'sd1000;
    for (int f = 1; f <= 130; f++) begin
      send_frame(y, lat);
      e = f <= 128 ? 1000 : 0;
      checks++; if (y !== 16'(e)) begin errors++; $display("FAIL impulse_frame%0d got %0d exp %0d", f, y, e); end
      checks++; if (lat !== 68) begin errors++; $display("FAIL impulse_latency%0d got %0d exp 68", f, lat); end
    end
  endtask

  task automatic test_band_sum;
    int lat;
    logic signed [15:0] y;
    do_reset();
    clear_rom();
    for (int k = 0; k < 8; k++) set_tap(k, 0, 65536);
    for (int k = 0; k < 8; k++) din[k] = 16'sd100;
    send_frame(y, lat);
    checks++; if (y !== 16'sd800) begin errors++; $display("FAIL band_sum got %0d exp 800", y); end
    checks++; if (lat !== 68) begin errors++; $display("FAIL band_sum_latency got %0d exp 68", lat); end
    @(negedge clock);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got %b exp 0", dout_valid); end
    checks++; if (dataout !== 16'sd800) begin errors++; $display("FAIL dataout_hold got %0d exp 800", dataout); end
    for (int k = 0; k < 8; k++) set_tap(k, 1, -65536);
    send_frame(y, lat);
    checks++; if (y !== -16'sd800) begin errors++; $display("FAIL band_sum_neg got %0d exp -800", y); end
  endtask

  task automatic test_saturation;
    int lat;
    logic signed [15:0] y;
    do_reset();
    clear_rom();
    for (int k = 0; k < 8; k++) set_tap(k, 0, 65536);
    for (int k = 0; k < 8; k++) din[k] = 16'sd30000;
    send_frame(y, lat);
    checks++; if (y !== 16'sd32767) begin errors++; $display("FAIL sat_pos got %0d exp 32767", y); end
    for (int k = 0; k < 8; k++) din[k] = -16'sd30000;
    send_frame(y, lat);
    checks++; if (y !== -16'sd32768) begin errors++; $display("FAIL sat_neg got %0d exp -32768", y); end
    for (int k = 0; k < 8; k++) din[k] = (k % 2 == 0) ? 16'sd30000 : -16'sd30000;
    send_frame(y, lat);
    checks++; if (y !== 16'sd0) begin errors++; $display("FAIL sat_alternating got %0d exp 0", y); end
    for (int k = 0; k < 8; k++) set_tap(k, 0, 1);
    din[0] = -16'sd1;
    send_frame(y, lat);
    checks++; if (y !== -16'sd1) begin errors++; $display("FAIL trunc_neg got %0d exp -1", y); end
    din[0] = 16'sd1;
    send_frame(y, lat);
    checks++; if (y !== 16'sd0) begin errors++; $display("FAIL trunc_pos got %0d exp 0", y); end
  endtask

  task automatic test_busy_collision;
    int nv, stray, addr_err, busy_err, r, ea;
    logic eb;
    logic signed [15:0] y1, y2;
    do_reset();
    clear_rom();
    for (int k = 0; k < 8; k++) begin
      set_tap(k, 0, 65536);
      set_tap(k, 1, 65536);
    end
    nv = 0; stray = 0; addr_err = 0; busy_err = 0; y1 = '0; y2 = '0;
    for (int e = 0; e < 140; e++) begin
      din_enable = (e == 0 || e == 10 || e == 68 || e == 69);
      din[0] = e == 0 ? 16'sd500 : e == 10 ? 16'sd777 : e == 68 ? 16'sd999 : e == 69 ? 16'sd321 : 16'sd0;
      @(negedge clock);
      r = e < 69 ? e : e - 69;
      eb = r <= 67;
      ea = (r >= 1 && r <= 64) ? r - 1 : 0;
      if (busy !== eb) busy_err++;
      if (coeffaddress !== 6'(ea)) addr_err++;
      if (dout_valid === 1'b1) begin
        nv++;
        if (e == 68) y1 = dataout;
        else if (e == 137) y2 = dataout;
        else stray++;
      end
    end
    din_enable = 1'b0;
    clear_din();
    checks++; if (nv !== 2) begin errors++; $display("FAIL collision_valid_count got %0d exp 2", nv); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL collision_valid_timing got %0d stray exp 0", stray); end
    checks++; if (y1 !== 16'sd500) begin errors++; $display("FAIL collision_first got %0d exp 500", y1); end
    checks++; if (y2 !== 16'sd821) begin errors++; $display("FAIL collision_second got %0d exp 821", y2); end
    checks++; if (addr_err !== 0) begin errors++; $display("FAIL collision_addr_sweep got %0d bad cycles exp 0", addr_err); end
    checks++; if (busy_err !== 0) begin errors++; $display("FAIL collision_busy got %0d bad cycles exp 0", busy_err); end
  endtask

  task automatic test_back_to_back;
    int lat;
    longint acc;
    int e;
    logic signed [15:0] y;
    do_reset();
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 128; n++) begin
        h[k][n] = int'($urandom_range(4095)) - 2048;
        set_tap(k, n, h[k][n]);
        mx[k][n] = 0;
      end
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 8; k++) begin
        din[k] = 16'(int'($urandom_range(65535)) - 32768);
        for (int n = 127; n > 0; n--) mx[k][n] = mx[k][n-1];
        mx[k][0] = int'(din[k]);
      end
      acc = 0;
      for (int k = 0; k < 8; k++)
        for (int n = 0; n < 128; n++) acc += longint'(h[k][n]) * longint'(mx[k][n]);
      acc = acc >>> 16;
      e = acc > 32767 ? 32767 : acc < -32768 ? -32768 : int'(acc);
      send_frame(y, lat);
      checks++; if (y !== 16'(e)) begin errors++; $display("FAIL b2b_frame%0d got %0d exp %0d", f, y, e); end
      checks++; if (lat !== 68) begin errors++; $display("FAIL b2b_latency%0d got %0d exp 68", f, lat); end
    end
  endtask

  initial begin
    clear_din();
    clear_rom();
    test_reset();
    test_impulse();
    test_band_sum();
    test_saturation();
    test_busy_collision();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/profir_synth.md
Name: profir_synth

Overview:
- 8-band FIR synthesis bank: the reconstruction end of the 8-band analysis bank.
- Accepts one 16-bit sample per band per frame and filters each band with its own 128-tap FIR.
- Sums the 8 band outputs into a single 16-bit reconstructed sample.
- Reads taps from the shared 64-word coefficient memory: each word packs 2 taps per band, one 36-bit bus per band.

Parameters:
- OUT_SHIFT, 16, right shift applied to the accumulator before saturation to 16 bits (Q16 coefficient scaling).
- ACC_W, 48, accumulator width in bits; must be ≥45.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- datain0..datain7  in  16 each  signed band samples, valid when din_enable=1
- din_enable  in  1  frame strobe, sampled on the rising edge
- busy  out  1  high while a frame is being computed
- coeffaddress  out  6  coefficient memory read address
- coeff0..coeff7  in  36 each  band-K word: [17:0] = h_K[2a], [35:18] = h_K[2a+1] (signed Q16); valid 1 cycle after coeffaddress=a (synchronous-read memory)
- dataout  out  16  signed reconstructed sample
- dout_valid  out  1  one-cycle pulse when dataout is updated

Behaviour:
- Reset (synchronous, active-high, one clock; reset is synchronous and active-high):
  - All 8×128 delay-line entries, accumulator and pipeline registers cleared.
  - dataout=0, dout_valid=0, busy=0, coeffaddress=0, state IDLE.
  - Reset mid-frame aborts the frame: no dout_valid, history lost.
- States: IDLE -> SHIFT -> ADDR (64 cycles) -> DRAIN -> OUT -> IDLE.
- IDLE:
  - coeffaddress=0, busy=0.
  - din_enable=1 at edge E0 accepts the frame.
- Edge E0 (SHIFT):
  - Each band line shifts x_K[n] <= x_K[n-1] for n=127..1, and x_K[0] <= datainK.
  - Accumulator cleared; busy=1 from E0.
- ADDR:
  - coeffaddress = a during cycles E1..E64, for a = 0..63.
  - Delay-line reads x_K[2a] and x_K[2a+1] are aligned with the returned coeff word at E(a+2).
- Products:
  - Each product is signed 16×18 = 34 bits, registered one stage.
  - The per-cycle sum of 16 products (8 bands × even/odd) is sign-extended to ACC_W and added to the accumulator.
  - No intermediate truncation.
- Result: y = Σ_K Σ_n h_K[n]·x_K[n]; final accumulate completes at edge E67.
- OUT, edge E68:
  - dataout <= saturate16(acc >>> OUT_SHIFT), using an arithmetic shift (truncate toward −inf).
  - Saturation limits: >32767 -> 32767, < −32768 -> −32768.
  - dout_valid=1 for exactly the cycle after E68.
  - busy deasserts at E68; coeffaddress returns to 0.
- Fixed latency: dout_valid high during the cycle following the 68th edge after the accepting edge. The minimum frame period is 69 cycles, so the next accept is possible at E69.
- dataout holds its value between frames.
- din_enable while busy=1 is ignored: sample dropped, no state change, no extra dout_valid.
- Delay lines persist across frames. Only reset clears them.

Test Plan:
- Reset: assert reset 2 cycles mid-frame -> dataout=0, dout_valid=0, busy=0, coeffaddress=0, and no dout_valid pulse for the aborted frame.
- Impulse:
  - Stimulus: all taps of all bands = 65536; frame 1 datain0=1000, others 0; then 129 frames of all-zero input.
  - Response: dataout=1000 on frames 1..128, 0 on frame 129; each dout_valid exactly 68 edges after its accept.
- Band sum:
  - Stimulus: h_K[0]=65536, all other taps 0; every band datain=100 for one frame.
  - Response: dataout=800.
  - Follow-up: with h_K[1]=−65536 added, a second frame of all 0s gives dataout=−800.
- Saturation, with h_K[0]=65536 only:
  - All bands 30000 -> 32767.
  - All bands −30000 -> −32768.
  - Bands alternating +30000/−30000 -> 0.
- Busy collision: pulse din_enable at E0, E10 and E68 -> one dout_valid only; the E69 strobe is accepted; coeffaddress sweeps 0..63 once per accepted frame.
- Back-to-back: frames every 69 cycles with random data and a random coefficient ROM model -> dataout matches the reference model on every dout_valid.
